// File: rtl/env_pkg.sv
// Shared types and default constants for the ADSR amplitude envelope.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package env_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } env_state_t;

   localparam int G_DEF            = 8;
   localparam int ATTACK_STEP_DEF  = 4;
   localparam int DECAY_STEP_DEF   = 1;
   localparam int SUSTAIN_LVL_DEF  = 192;
   localparam int RELEASE_STEP_DEF = 2;
   localparam int GAIN_MAX         = (1 << G_DEF) - 1;

endpackage

// File: rtl/adsr_envelope_if.sv
// Sample/control bundle between sine generator, sequencer and envelope stage.
// Latency: none (wiring only).
// Backpressure: none; samples are strobed by fs_clk and never stalled.
interface adsr_envelope_if #(
   parameter int N = 8,
   parameter int G = 8
);
   logic         fs_clk;
   logic         note_on;
   logic         note_off;
   logic [N-1:0] pos_in;
   logic [N-1:0] neg_in;
   logic [N-1:0] pos_out;
   logic [N-1:0] neg_out;
   logic [G-1:0] gain;
   logic         active;

   // Driver side: sequencer and sine generator
   modport master (
      output fs_clk, note_on, note_off, pos_in, neg_in,
      input  pos_out, neg_out, gain, active
   );

   // Envelope side
   modport slave (
      input  fs_clk, note_on, note_off, pos_in, neg_in,
      output pos_out, neg_out, gain, active
   );
endinterface

// File: rtl/env_scale.sv
// Registered sample scaler: out = (sample * gain) >> G, truncated.
// Latency: one clk after the enable strobe; output held between strobes.
// Backpressure: none; every enabled cycle loads a new result.
module env_scale #(
   parameter int N = 8,
   parameter int G = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [N-1:0] sample,
   input  logic [G-1:0] gain,
   output logic [N-1:0] scaled
);

   logic [N+G-1:0] prod;

   assign prod = {{G{1'b0}}, sample} * {{N{1'b0}}, gain};

   // Keep the upper N bits of the product on each sample strobe
   always_ff @(posedge clk) begin
      if (reset)
         scaled <= '0;
      else if (en)
         scaled <= prod[N+G-1:G];
   end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope: steps an 8-bit gain on fs_clk and scales both half-waves by it.
// Latency: one clk from fs_clk to new pos_out/neg_out; events act on the next edge.
// Backpressure: none; note_on/note_off pulses are always accepted or ignored in one clk.
module adsr_envelope
   import env_pkg::*;
#(
   parameter int N            = 8,
   parameter int G            = G_DEF,
   parameter int ATTACK_STEP  = ATTACK_STEP_DEF,
   parameter int DECAY_STEP   = DECAY_STEP_DEF,
   parameter int SUSTAIN_LVL  = SUSTAIN_LVL_DEF,
   parameter int RELEASE_STEP = RELEASE_STEP_DEF
) (
   input logic              clk,
   input logic              reset,
   adsr_envelope_if.slave   bus
);

   // Arithmetic is carried in G+1 bits so saturation and floor checks cannot wrap
   localparam logic [G:0]   GMAX_W    = (G+1)'((1 << G) - 1);
   localparam logic [G:0]   A_STEP_W  = (G+1)'(ATTACK_STEP);
   localparam logic [G:0]   DEC_FLOOR = (G+1)'(SUSTAIN_LVL + DECAY_STEP);
   localparam logic [G:0]   R_STEP_W  = (G+1)'(RELEASE_STEP);
   localparam logic [G-1:0] D_STEP_G  = G'(DECAY_STEP);
   localparam logic [G-1:0] R_STEP_G  = G'(RELEASE_STEP);
   localparam logic [G-1:0] SUS_G     = G'(SUSTAIN_LVL);
   localparam logic [G-1:0] GMAX_G    = G'((1 << G) - 1);

   env_state_t   state, state_nxt;
   logic [G-1:0] gain_q, gain_nxt;
   logic         active_q, active_nxt;
   logic [G:0]   wide, sum;
   logic         rel_ok;

   assign wide   = {1'b0, gain_q};
   assign sum    = wide + A_STEP_W;
   assign rel_ok = (state == S_ATTACK) || (state == S_DECAY) || (state == S_SUSTAIN);

   // State, gain and activity registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         gain_q   <= '0;
         active_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         gain_q   <= gain_nxt;
         active_q <= active_nxt;
      end
   end

   // Events pre-empt gain stepping; stepping only happens on quiet strobes
   always_comb begin
      state_nxt = state;
      gain_nxt  = gain_q;
      if (bus.note_on) begin
         state_nxt = S_ATTACK;
      end else if (bus.note_off && rel_ok) begin
         state_nxt = S_RELEASE;
      end else if (bus.fs_clk) begin
         case (state)
            S_ATTACK: begin
               if (sum >= GMAX_W) begin
                  gain_nxt  = GMAX_G;
                  state_nxt = S_DECAY;
               end else begin
                  gain_nxt  = sum[G-1:0];
               end
            end
            S_DECAY: begin
               if (wide <= DEC_FLOOR) begin
                  gain_nxt  = SUS_G;
                  state_nxt = S_SUSTAIN;
               end else begin
                  gain_nxt  = gain_q - D_STEP_G;
               end
            end
            S_RELEASE: begin
               if (wide <= R_STEP_W) begin
                  gain_nxt  = '0;
                  state_nxt = S_IDLE;
               end else begin
                  gain_nxt  = gain_q - R_STEP_G;
               end
            end
            S_IDLE:    gain_nxt = '0;
            default:   gain_nxt = gain_q;
         endcase
      end
   end

   // Activity flag tracks the state being entered so it lines up with state
   always_comb begin
      active_nxt = (state_nxt != S_IDLE);
   end

   assign bus.gain   = gain_q;
   assign bus.active = active_q;

   env_scale #(.N(N), .G(G)) u_scale_pos (
      .clk    (clk),
      .reset  (reset),
      .en     (bus.fs_clk),
      .sample (bus.pos_in),
      .gain   (gain_q),
      .scaled (bus.pos_out)
   );

   env_scale #(.N(N), .G(G)) u_scale_neg (
      .clk    (clk),
      .reset  (reset),
      .en     (bus.fs_clk),
      .sample (bus.neg_in),
      .gain   (gain_q),
      .scaled (bus.neg_out)
   );

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: behavioural model feeds a scoreboard
// queue each cycle; outputs are popped and compared 1 time unit after the edge.
// Scenario tasks add explicit checks on the key envelope milestones.
`timescale 1ns/1ps
module tb_adsr_envelope;
   import env_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;

   adsr_envelope_if #(.N(8), .G(8)) bus ();

   adsr_envelope dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         gain;
      int         pos;
      int         neg;
      bit         act;
      env_state_t st;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_err = 0;
   int         m_gain = 0;
   int         m_pos = 0;
   int         m_neg = 0;
   env_state_t m_st = S_IDLE;
   int         cyc = 0;

   // One clock: drive inputs, advance the model, push expectation, pop and compare
   task automatic drive(input bit on, input bit off, input bit fs, input bit rst);
      exp_t e;
      bus.note_on  = on;
      bus.note_off = off;
      bus.fs_clk   = fs;
      reset        = rst;
      if (rst) begin
         m_st = S_IDLE; m_gain = 0; m_pos = 0; m_neg = 0;
      end else begin
         if (fs) begin
            m_pos = (int'(bus.pos_in) * m_gain) / 256;
            m_neg = (int'(bus.neg_in) * m_gain) / 256;
         end
         if (on) begin
            m_st = S_ATTACK;
         end else if (off && (m_st == S_ATTACK || m_st == S_DECAY || m_st == S_SUSTAIN)) begin
            m_st = S_RELEASE;
         end else if (fs) begin
            case (m_st)
               S_ATTACK: begin
                  m_gain = m_gain + 4;
                  if (m_gain >= 255) begin m_gain = 255; m_st = S_DECAY; end
               end
               S_DECAY: begin
                  m_gain = m_gain - 1;
                  if (m_gain <= 192) begin m_gain = 192; m_st = S_SUSTAIN; end
               end
               S_RELEASE: begin
                  m_gain = m_gain - 2;
                  if (m_gain <= 0) begin m_gain = 0; m_st = S_IDLE; end
               end
               default: ;
            endcase
         end
      end
      e.gain = m_gain; e.pos = m_pos; e.neg = m_neg; e.act = (m_st != S_IDLE); e.st = m_st;
      sb.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      bus.note_on = 1'b0; bus.note_off = 1'b0; bus.fs_clk = 1'b0; reset = 1'b0;
      e = sb.pop_front();
      n_cmp += 5;
      if (int'(bus.gain) !== e.gain) begin
         n_err++; $display("FAIL sb_gain cyc=%0d got=%0d exp=%0d", cyc, bus.gain, e.gain);
      end
      if (int'(bus.pos_out) !== e.pos) begin
         n_err++; $display("FAIL sb_pos cyc=%0d got=%0d exp=%0d", cyc, bus.pos_out, e.pos);
      end
      if (int'(bus.neg_out) !== e.neg) begin
         n_err++; $display("FAIL sb_neg cyc=%0d got=%0d exp=%0d", cyc, bus.neg_out, e.neg);
      end
      if (bus.active !== e.act) begin
         n_err++; $display("FAIL sb_active cyc=%0d got=%0b exp=%0b", cyc, bus.active, e.act);
      end
      if (dut.state !== e.st) begin
         n_err++; $display("FAIL sb_state cyc=%0d got=%0d exp=%0d", cyc, dut.state, e.st);
      end
   endtask

   // One sample strobe followed by gap quiet cycles
   task automatic strobe(input int gap);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < gap; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (bus.gain !== 8'd0 || bus.pos_out !== 8'd0 || bus.neg_out !== 8'd0 || bus.active !== 1'b0) begin
         n_err++; $display("FAIL reset_state got gain=%0d pos=%0d neg=%0d act=%0b exp all 0",
                           bus.gain, bus.pos_out, bus.neg_out, bus.active);
      end
      for (int i = 0; i < 4; i++) strobe(2);
      n_cmp++;
      if (bus.gain !== 8'd0) begin
         n_err++; $display("FAIL idle_hold got=%0d exp=0", bus.gain);
      end
   endtask

   task automatic test_attack();
      bus.pos_in = 8'd200;
      bus.neg_in = 8'd255;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int s = 1; s <= 64; s++) begin
         strobe(124);
         if (s == 1) begin
            n_cmp++;
            if (bus.gain !== 8'd4) begin
               n_err++; $display("FAIL attack_first got=%0d exp=4", bus.gain);
            end
         end
         if (s == 63) begin
            n_cmp++;
            if (bus.gain !== 8'd252) begin
               n_err++; $display("FAIL attack_252 got=%0d exp=252", bus.gain);
            end
         end
      end
      n_cmp++;
      if (bus.gain !== 8'd255 || dut.state !== S_DECAY) begin
         n_err++; $display("FAIL attack_sat got gain=%0d st=%0d exp gain=255 st=%0d",
                           bus.gain, dut.state, S_DECAY);
      end
   endtask

   task automatic test_scale_at_128();
      // From a fresh attack, the 33rd strobe is the first to use gain 128
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int s = 1; s <= 33; s++) strobe(3);
      n_cmp++;
      if (bus.pos_out !== 8'd100) begin
         n_err++; $display("FAIL scale_128 got=%0d exp=100", bus.pos_out);
      end
      for (int s = 34; s <= 64; s++) strobe(3);
      strobe(3);
      n_cmp++;
      if (bus.neg_out !== 8'd254) begin
         n_err++; $display("FAIL full_scale_trunc got=%0d exp=254", bus.neg_out);
      end
   endtask

   task automatic test_decay_sustain();
      // One decay strobe was already taken by the previous task
      for (int s = 2; s <= 63; s++) strobe(3);
      n_cmp++;
      if (bus.gain !== 8'd192 || dut.state !== S_SUSTAIN) begin
         n_err++; $display("FAIL decay_end got gain=%0d st=%0d exp gain=192 st=%0d",
                           bus.gain, dut.state, S_SUSTAIN);
      end
      for (int s = 0; s < 500; s++) begin
         bus.neg_in = 8'($urandom_range(0, 255));
         strobe(3);
      end
      n_cmp++;
      if (bus.gain !== 8'd192) begin
         n_err++; $display("FAIL sustain_hold got=%0d exp=192", bus.gain);
      end
   endtask

   task automatic test_release();
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      strobe(3);
      n_cmp++;
      if (bus.gain !== 8'd190) begin
         n_err++; $display("FAIL release_first got=%0d exp=190", bus.gain);
      end
      for (int s = 2; s <= 96; s++) strobe(3);
      n_cmp++;
      if (bus.gain !== 8'd0 || bus.active !== 1'b0 || dut.state !== S_IDLE) begin
         n_err++; $display("FAIL release_end got gain=%0d act=%0b st=%0d exp 0/0/IDLE",
                           bus.gain, bus.active, dut.state);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      strobe(3);
      n_cmp++;
      if (bus.pos_out !== 8'd0) begin
         n_err++; $display("FAIL release_out got=%0d exp=0", bus.pos_out);
      end
   endtask

   task automatic test_retrigger();
      int guard;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      guard = 0;
      while (m_st != S_SUSTAIN && guard < 400) begin strobe(2); guard++; end
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      guard = 0;
      while (int'(bus.gain) != 100 && guard < 200) begin strobe(2); guard++; end
      n_cmp++;
      if (bus.gain !== 8'd100 || dut.state !== S_RELEASE) begin
         n_err++; $display("FAIL retrig_setup got gain=%0d st=%0d exp 100/RELEASE", bus.gain, dut.state);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (bus.gain !== 8'd100 || dut.state !== S_ATTACK) begin
         n_err++; $display("FAIL retrig_keep got gain=%0d st=%0d exp 100/ATTACK", bus.gain, dut.state);
      end
      strobe(2);
      n_cmp++;
      if (bus.gain !== 8'd104) begin
         n_err++; $display("FAIL retrig_step got=%0d exp=104", bus.gain);
      end
   endtask

   task automatic test_back_to_back();
      int guard;
      guard = 0;
      while (m_st != S_SUSTAIN && guard < 400) begin strobe(0); guard++; end
      n_cmp++;
      if (dut.state !== S_SUSTAIN) begin
         n_err++; $display("FAIL b2b_sustain got st=%0d exp=%0d", dut.state, S_SUSTAIN);
      end
      // note_on and note_off together, on a strobe: attack wins, gain not stepped
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (dut.state !== S_ATTACK || bus.gain !== 8'd192) begin
         n_err++; $display("FAIL on_off_same got st=%0d gain=%0d exp ATTACK/192", dut.state, bus.gain);
      end
      strobe(0);
      n_cmp++;
      if (bus.gain !== 8'd196) begin
         n_err++; $display("FAIL on_off_step got=%0d exp=196", bus.gain);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int s = 0; s < 15; s++) strobe(1);
      n_cmp++;
      if (bus.gain !== 8'd60) begin
         n_err++; $display("FAIL mid_setup got=%0d exp=60", bus.gain);
      end
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (bus.gain !== 8'd0 || bus.pos_out !== 8'd0 || bus.neg_out !== 8'd0 || dut.state !== S_IDLE) begin
         n_err++; $display("FAIL mid_reset got gain=%0d pos=%0d neg=%0d st=%0d exp 0/0/0/IDLE",
                           bus.gain, bus.pos_out, bus.neg_out, dut.state);
      end
      for (int s = 0; s < 5; s++) strobe(1);
      n_cmp++;
      if (bus.gain !== 8'd0) begin
         n_err++; $display("FAIL mid_idle got=%0d exp=0", bus.gain);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      strobe(1);
      n_cmp++;
      if (bus.gain !== 8'd4) begin
         n_err++; $display("FAIL mid_restart got=%0d exp=4", bus.gain);
      end
   endtask

   initial begin
      bus.fs_clk = 1'b0; bus.note_on = 1'b0; bus.note_off = 1'b0;
      bus.pos_in = 8'd200; bus.neg_in = 8'd255;
      #2;
      test_reset();
      test_attack();
      test_scale_at_128();
      test_decay_sustain();
      test_release();
      test_retrigger();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
Amplitude envelope stage between the sine generator and the two PWM DACs.
- Scales the positive and negative half-wave samples by an 8-bit gain that follows attack/decay/sustain/release.
- Note changes in the melody player therefore fade in and out instead of clicking.
- Gain advances only on the sample strobe (fs_clk, 8 kHz). The melody sequencer drives note_on / note_off.

Parameters:
N, 8, sample width of pos/neg inputs and outputs
G, 8, gain width; full scale = 2^G-1
ATTACK_STEP, 4, gain increment per fs_clk in ATTACK
DECAY_STEP, 1, gain decrement per fs_clk in DECAY
SUSTAIN_LVL, 192, sustain gain; must satisfy 0 < SUSTAIN_LVL < 2^G-1
RELEASE_STEP, 2, gain decrement per fs_clk in RELEASE

Ports:
clk  in  1  system clock (1 MHz)
reset  in  1  synchronous, active-high reset
fs_clk  in  1  one-clk-wide sample strobe
note_on  in  1  one-clk pulse: start or retrigger the envelope
note_off  in  1  one-clk pulse: begin release
pos_in  in  N  positive half-wave sample from the sine generator
neg_in  in  N  negative half-wave sample from the sine generator
pos_out  out  N  scaled positive sample, to dac_pos t_on
neg_out  out  N  scaled negative sample, to dac_neg t_on
gain  out  G  current envelope gain
active  out  1  high when state != IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE, gain=0, pos_out=0, neg_out=0, active=0. Reset overrides all other inputs in the same cycle, including mid-note.
- States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- Event transitions take effect on the next clk edge, whether or not fs_clk is high:
  - note_on, any state -> ATTACK; gain is kept, so a retrigger does not click.
  - note_off in ATTACK, DECAY or SUSTAIN -> RELEASE.
  - note_off in IDLE or RELEASE is ignored.
  - note_on and note_off in the same cycle: note_on wins.
  - In any cycle with an accepted event, gain is not stepped, even if fs_clk is high.
- Gain stepping happens only on fs_clk cycles with no accepted event:
  - ATTACK: gain += ATTACK_STEP, saturating at 2^G-1. Move to DECAY in the same cycle the saturated value is written.
  - DECAY: gain -= DECAY_STEP, clamped at SUSTAIN_LVL. Move to SUSTAIN when the clamped value is written.
  - SUSTAIN: gain held.
  - RELEASE: gain -= RELEASE_STEP, floored at 0. Move to IDLE when 0 is written.
  - IDLE: gain held at 0.
- Arithmetic is done in G+1 bits so saturation and floor detection cannot wrap.
- Scaling, on every fs_clk cycle regardless of events:
  - pos_out <= (pos_in * gain) >> G and neg_out <= (neg_in * gain) >> G.
  - Uses the gain value before that cycle's update. Product is N+G bits; keep the upper N bits, truncated.
- Outputs are registered. pos_out/neg_out change only on the clk edge after fs_clk and are held between strobes.
  - Latency: one clk from the fs_clk strobe to the new output.
- Full-scale gain 255 with input 255 gives 254. This truncation is accepted and no rounding is applied.
- active is registered and equals (state != IDLE).

Decomposition:
- Package env_pkg holds:
  - typedef env_state_t (the five states);
  - default step and sustain constants;
  - localparam GAIN_MAX = 2^G-1.
- Sub-module env_scale: registered (sample * gain) >> G with a fs_clk enable, instantiated twice (pos and neg).
- The top holds the FSM and gain register.

Test Plan:
- Reset, then note_on, fs_clk every 125 clk, pos_in=200 constant:
  - gain reads 4, 8, ... 252, then 255 on the 64th strobe; state is DECAY after that edge.
  - pos_out on the strobe after gain first reaches 128 is 100.
- Continue to DECAY: gain reaches 192 after 63 further strobes, then stays 192 in SUSTAIN across 500 strobes.
- note_off in SUSTAIN: RELEASE steps gain 190, 188, ... 0 after 96 strobes; state IDLE, active=0, and pos_out=0 on the following strobe.
- note_on during RELEASE at gain=100: state goes to ATTACK with gain still 100, and the next strobe gives gain=104.
- note_on and note_off in the same cycle while in SUSTAIN: state goes to ATTACK. note_on coincident with fs_clk: gain unchanged that cycle.
- Assert reset mid-ATTACK at gain=60: the next cycle shows gain=0, pos_out=neg_out=0, state IDLE, and fs_clk strobes do not change gain until note_on.
